ram_dma_ci_rw: RTL and testbench

//  Custom-instruction DMA with a local dual-port word buffer, moving blocks in both directions: bus->buffer
//  (read) and buffer->bus (write). CPU reaches the buffer and the DMA registers through the CI port. A bus

---
 rtl/ram_dma_ci_pkg.sv | 28 ++
 rtl/dualPortSSRAM.sv | 27 ++
 rtl/ram_dma_bus_engine.sv | 178 +++++++++++++++++
 rtl/ram_dma_ci_rw.sv | 174 +++++++++++++++++
 tb/tb_ram_dma_ci_rw.sv | 346 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_dma_ci_pkg.sv
// Shared definitions for the custom-instruction DMA: register selects, bit indices and FSM states.
package ram_dma_ci_pkg;

   localparam logic [2:0] SelMem     = 3'd0;
   localparam logic [2:0] SelBusAddr = 3'd1;
   localparam logic [2:0] SelBufAddr = 3'd2;
   localparam logic [2:0] SelBlkSize = 3'd3;
   localparam logic [2:0] SelBurst   = 3'd4;
   localparam logic [2:0] SelCtrl    = 3'd5;
   localparam logic [2:0] SelStatus  = 3'd6;

   localparam int unsigned CtrlRdBit   = 0;
   localparam int unsigned CtrlWrBit   = 1;
   localparam int unsigned StatBusyBit = 0;
   localparam int unsigned StatErrBit  = 1;
   localparam int unsigned StatDoneBit = 2;

   typedef enum logic [2:0] {
      StIdle,
      StReq,
      StBegin,
      StRdData,
      StWrData,
      StErr,
      StNext
   } dma_state_e;

endpackage

// File: rtl/dualPortSSRAM.sv
// Dual-port synchronous SRAM, one clock, registered read on both ports; port B wins a write collision.
module dualPortSSRAM #(
   parameter int unsigned AddrBits = 9,
   parameter int unsigned DataBits = 32
) (
   input  logic                clk_i,
   input  logic [AddrBits-1:0] addr_a_i,
   input  logic                we_a_i,
   input  logic [DataBits-1:0] wdata_a_i,
   output logic [DataBits-1:0] rdata_a_o,
   input  logic [AddrBits-1:0] addr_b_i,
   input  logic                we_b_i,
   input  logic [DataBits-1:0] wdata_b_i,
   output logic [DataBits-1:0] rdata_b_o
);

   logic [DataBits-1:0] mem_q [2**AddrBits];

   always_ff @(posedge clk_i) begin
      if (we_a_i) mem_q[addr_a_i] <= wdata_a_i;
      // Later non-blocking write takes effect, so the DMA side wins.
      if (we_b_i) mem_q[addr_b_i] <= wdata_b_i;
      rdata_a_o <= mem_q[addr_a_i];
      rdata_b_o <= mem_q[addr_b_i];
   end

endmodule

// File: rtl/ram_dma_bus_engine.sv
// Bus master engine: splits a block into bursts, moves words between the bus and buffer port B.
module ram_dma_bus_engine
   import ram_dma_ci_pkg::*;
#(
   parameter int unsigned AddrBits = 9
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                cfg_bus_we_i,
   input  logic                cfg_buf_we_i,
   input  logic [31:0]         cfg_wdata_i,
   input  logic                start_i,
   input  logic                dir_wr_i,
   input  logic [AddrBits:0]   block_size_i,
   input  logic [7:0]          burst_i,
   output logic                busy_o,
   output logic                dir_o,
   output logic                done_o,
   output logic                err_o,
   output logic [31:0]         bus_addr_o,
   output logic [AddrBits-1:0] buf_addr_o,
   output logic [AddrBits-1:0] ram_addr_o,
   output logic                ram_we_o,
   output logic [31:0]         ram_wdata_o,
   input  logic [31:0]         ram_rdata_i,
   input  logic                granted_i,
   input  logic [31:0]         rdata_i,
   input  logic                end_i,
   input  logic                dvalid_i,
   input  logic                busy_i,
   input  logic                error_i,
   output logic                request_o,
   output logic [31:0]         addr_data_o,
   output logic [3:0]          byte_en_o,
   output logic [7:0]          burst_size_o,
   output logic                rnw_o,
   output logic                begin_o,
   output logic                end_o,
   output logic                dvalid_o,
   output logic                irq_o
);

   dma_state_e          state_q, state_d;
   logic [31:0]         bus_addr_q, bus_addr_d;
   logic [AddrBits-1:0] buf_addr_q, buf_addr_d;
   logic [AddrBits:0]   remaining_q, remaining_d;
   logic [8:0]          beats_q, beats_d;
   logic                dir_q, dir_d;

   logic [15:0] burst_beats, rem_ext, beats_calc;
   logic [8:0]  beats_m1;

   assign burst_beats = 16'(burst_i) + 16'd1;
   assign rem_ext     = 16'(remaining_q);
   assign beats_calc  = (burst_beats < rem_ext) ? burst_beats : rem_ext;
   assign beats_m1    = beats_q - 9'd1;

   assign busy_o     = (state_q != StIdle);
   assign dir_o      = dir_q;
   assign bus_addr_o = bus_addr_q;
   assign buf_addr_o = buf_addr_q;

   always_comb begin
      state_d      = state_q;
      bus_addr_d   = bus_addr_q;
      buf_addr_d   = buf_addr_q;
      remaining_d  = remaining_q;
      beats_d      = beats_q;
      dir_d        = dir_q;
      done_o       = 1'b0;
      err_o        = 1'b0;
      ram_addr_o   = buf_addr_q;
      ram_we_o     = 1'b0;
      ram_wdata_o  = rdata_i;
      request_o    = 1'b0;
      addr_data_o  = '0;
      byte_en_o    = '0;
      burst_size_o = '0;
      rnw_o        = 1'b0;
      begin_o      = 1'b0;
      end_o        = 1'b0;
      dvalid_o     = 1'b0;
      irq_o        = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (cfg_bus_we_i) bus_addr_d = {cfg_wdata_i[31:2], 2'b00};
            if (cfg_buf_we_i) buf_addr_d = cfg_wdata_i[AddrBits-1:0];
            if (start_i) begin
               remaining_d = block_size_i;
               dir_d       = dir_wr_i;
               state_d     = StReq;
            end
         end
         StReq: begin
            request_o = 1'b1;
            if (granted_i) begin
               beats_d = beats_calc[8:0];
               state_d = StBegin;
            end
         end
         StBegin: begin
            // Port B is addressed here so the first write beat is ready next cycle.
            begin_o      = 1'b1;
            addr_data_o  = bus_addr_q;
            byte_en_o    = 4'hF;
            burst_size_o = beats_m1[7:0];
            rnw_o        = ~dir_q;
            state_d      = dir_q ? StWrData : StRdData;
         end
         StRdData: begin
            if (error_i) begin
               state_d = StErr;
            end else begin
               if (dvalid_i && (remaining_q != '0)) begin
                  ram_we_o    = 1'b1;
                  buf_addr_d  = buf_addr_q + 1'b1;
                  bus_addr_d  = bus_addr_q + 32'd4;
                  remaining_d = remaining_q - 1'b1;
               end
               if (end_i) state_d = StNext;
            end
         end
         StWrData: begin
            dvalid_o    = 1'b1;
            byte_en_o   = 4'hF;
            addr_data_o = ram_rdata_i;
            if (error_i) begin
               state_d = StErr;
            end else if (!busy_i) begin
               buf_addr_d  = buf_addr_q + 1'b1;
               bus_addr_d  = bus_addr_q + 32'd4;
               remaining_d = remaining_q - 1'b1;
               beats_d     = beats_m1;
               if (beats_q == 9'd1) state_d = StNext;
            end
            // Holding the address on a stall keeps the registered read output stable.
            ram_addr_o = buf_addr_d;
         end
         StNext: begin
            end_o = dir_q;
            if (remaining_q == '0) begin
               done_o  = 1'b1;
               irq_o   = 1'b1;
               state_d = StIdle;
            end else begin
               state_d = StReq;
            end
         end
         StErr: begin
            end_o   = 1'b1;
            err_o   = 1'b1;
            irq_o   = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= StIdle;
         bus_addr_q  <= '0;
         buf_addr_q  <= '0;
         remaining_q <= '0;
         beats_q     <= '0;
         dir_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         bus_addr_q  <= bus_addr_d;
         buf_addr_q  <= buf_addr_d;
         remaining_q <= remaining_d;
         beats_q     <= beats_d;
         dir_q       <= dir_d;
      end
   end

endmodule

// File: rtl/ram_dma_ci_rw.sv
// Custom-instruction DMA top: CI decode, register file and local word buffer beside the bus engine.
module ram_dma_ci_rw
   import ram_dma_ci_pkg::*;
#(
   parameter logic [7:0]  CUSTOM_ID = 8'h00,
   parameter int unsigned ADDR_BITS = 9,
   parameter int unsigned MAX_BURST = 16
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        start,
   input  logic [7:0]  ciN,
   input  logic [31:0] valueA,
   input  logic [31:0] valueB,
   output logic        done,
   output logic [31:0] result,
   input  logic        granted,
   input  logic [31:0] address_data_in,
   input  logic        end_transaction_in,
   input  logic        data_valid_in,
   input  logic        busy_in,
   input  logic        error_in,
   output logic        request,
   output logic [31:0] address_data_out,
   output logic [3:0]  byte_enables_out,
   output logic [7:0]  burst_size_out,
   output logic        read_n_write_out,
   output logic        begin_transaction_out,
   output logic        end_transaction_out,
   output logic        data_valid_out,
   output logic        irq
);

   localparam int unsigned A        = ADDR_BITS;
   localparam logic [7:0]  BurstMax = 8'(MAX_BURST - 1);

   logic           ci_active, ci_ok, ci_wr, reg_we, start_ok;
   logic [2:0]     ci_sel;
   logic [7:0]     burst_clamped;
   logic [31:0]    reg_rdata;
   logic           ram_we_a, ram_we_b;
   logic [A-1:0]   ram_addr_b;
   logic [31:0]    ram_rdata_a, ram_rdata_b, ram_wdata_b;
   logic           eng_busy, eng_dir, eng_done, eng_err;
   logic [31:0]    eng_bus_addr;
   logic [A-1:0]   eng_buf_addr;

   logic [A:0]     block_size_q, block_size_d;
   logic [7:0]     burst_q, burst_d;
   logic           err_q, err_d, done_q, done_d, rd_pending_q, rd_pending_d;

   assign ci_active     = start && (ciN == CUSTOM_ID);
   assign ci_wr         = valueA[A];
   assign ci_sel        = valueA[A+3:A+1];
   assign ci_ok         = ci_active && (valueA[31:A+4] == '0);
   assign reg_we        = ci_ok && ci_wr && !eng_busy;
   assign ram_we_a      = ci_ok && ci_wr && (ci_sel == SelMem);
   assign burst_clamped = (valueB[7:0] > BurstMax) ? BurstMax : valueB[7:0];
   assign start_ok      = reg_we && (ci_sel == SelCtrl) && (block_size_q != '0) &&
                          (valueB[CtrlRdBit] ^ valueB[CtrlWrBit]);

   always_comb begin
      block_size_d = block_size_q;
      burst_d      = burst_q;
      err_d        = err_q;
      done_d       = done_q;
      rd_pending_d = ci_ok && !ci_wr && (ci_sel == SelMem) && !rd_pending_q;
      if (reg_we && (ci_sel == SelBlkSize)) block_size_d = valueB[A:0];
      if (reg_we && (ci_sel == SelBurst))   burst_d      = burst_clamped;
      if (start_ok) begin
         err_d  = 1'b0;
         done_d = 1'b0;
      end
      if (eng_err)  err_d  = 1'b1;
      if (eng_done) done_d = 1'b1;
   end

   always_comb begin
      reg_rdata = '0;
      case (ci_sel)
         SelBusAddr: reg_rdata = eng_bus_addr;
         SelBufAddr: reg_rdata = 32'(eng_buf_addr);
         SelBlkSize: reg_rdata = 32'(block_size_q);
         SelBurst:   reg_rdata = 32'(burst_q);
         SelCtrl:    reg_rdata = {30'd0, eng_busy & eng_dir, eng_busy & ~eng_dir};
         SelStatus:  reg_rdata = {29'd0, done_q, err_q, eng_busy};
         default:    reg_rdata = '0;
      endcase
   end

   // Buffer reads finish a cycle late; everything else, including bad encodings, finishes now.
   always_comb begin
      done   = 1'b0;
      result = '0;
      if (rd_pending_q) begin
         done   = 1'b1;
         result = ram_rdata_a;
      end else if (ci_active) begin
         done = !(ci_ok && !ci_wr && (ci_sel == SelMem));
         if (ci_ok && !ci_wr) result = reg_rdata;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         block_size_q <= '0;
         burst_q      <= '0;
         err_q        <= 1'b0;
         done_q       <= 1'b0;
         rd_pending_q <= 1'b0;
      end else begin
         block_size_q <= block_size_d;
         burst_q      <= burst_d;
         err_q        <= err_d;
         done_q       <= done_d;
         rd_pending_q <= rd_pending_d;
      end
   end

   dualPortSSRAM #(
      .AddrBits (A),
      .DataBits (32)
   ) u_buffer (
      .clk_i     (clock),
      .addr_a_i  (valueA[A-1:0]),
      .we_a_i    (ram_we_a),
      .wdata_a_i (valueB),
      .rdata_a_o (ram_rdata_a),
      .addr_b_i  (ram_addr_b),
      .we_b_i    (ram_we_b),
      .wdata_b_i (ram_wdata_b),
      .rdata_b_o (ram_rdata_b)
   );

   ram_dma_bus_engine #(
      .AddrBits (A)
   ) u_engine (
      .clk_i        (clock),
      .rst_ni       (reset_n),
      .cfg_bus_we_i (reg_we && (ci_sel == SelBusAddr)),
      .cfg_buf_we_i (reg_we && (ci_sel == SelBufAddr)),
      .cfg_wdata_i  (valueB),
      .start_i      (start_ok),
      .dir_wr_i     (valueB[CtrlWrBit]),
      .block_size_i (block_size_q),
      .burst_i      (burst_q),
      .busy_o       (eng_busy),
      .dir_o        (eng_dir),
      .done_o       (eng_done),
      .err_o        (eng_err),
      .bus_addr_o   (eng_bus_addr),
      .buf_addr_o   (eng_buf_addr),
      .ram_addr_o   (ram_addr_b),
      .ram_we_o     (ram_we_b),
      .ram_wdata_o  (ram_wdata_b),
      .ram_rdata_i  (ram_rdata_b),
      .granted_i    (granted),
      .rdata_i      (address_data_in),
      .end_i        (end_transaction_in),
      .dvalid_i     (data_valid_in),
      .busy_i       (busy_in),
      .error_i      (error_in),
      .request_o    (request),
      .addr_data_o  (address_data_out),
      .byte_en_o    (byte_enables_out),
      .burst_size_o (burst_size_out),
      .rnw_o        (read_n_write_out),
      .begin_o      (begin_transaction_out),
      .end_o        (end_transaction_out),
      .dvalid_o     (data_valid_out),
      .irq_o        (irq)
   );

endmodule

// File: tb/tb_ram_dma_ci_rw.sv
// Directed bench for ram_dma_ci_rw: CI access, burst reads/writes, stall, error, wrap and reset.
module tb_ram_dma_ci_rw;
   import ram_dma_ci_pkg::*;

   localparam int unsigned A = 9;

   logic        clock, reset_n, start;
   logic [7:0]  ciN;
   logic [31:0] valueA, valueB, result, address_data_in, address_data_out;
   logic        done, granted, end_transaction_in, data_valid_in, busy_in, error_in;
   logic        request, read_n_write_out, begin_transaction_out, end_transaction_out;
   logic        data_valid_out, irq;
   logic [3:0]  byte_enables_out;
   logic [7:0]  burst_size_out;

   int n_cmp = 0;
   int n_err = 0;
   int irq_cnt = 0;
   logic [31:0] exp_q[$];

   ram_dma_ci_rw dut (
      .clock                 (clock),
      .reset_n               (reset_n),
      .start                 (start),
      .ciN                   (ciN),
      .valueA                (valueA),
      .valueB                (valueB),
      .done                  (done),
      .result                (result),
      .granted               (granted),
      .address_data_in       (address_data_in),
      .end_transaction_in    (end_transaction_in),
      .data_valid_in         (data_valid_in),
      .busy_in               (busy_in),
      .error_in              (error_in),
      .request               (request),
      .address_data_out      (address_data_out),
      .byte_enables_out      (byte_enables_out),
      .burst_size_out        (burst_size_out),
      .read_n_write_out      (read_n_write_out),
      .begin_transaction_out (begin_transaction_out),
      .end_transaction_out   (end_transaction_out),
      .data_valid_out        (data_valid_out),
      .irq                   (irq)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(posedge clock) if (irq) irq_cnt <= irq_cnt + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      assert (obs === expv)
      else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic ci(input logic wr, input logic [2:0] sel, input logic [31:0] idx,
                     input logic [31:0] data, output logic [31:0] res, output int lat);
      @(negedge clock);
      start  = 1'b1;
      ciN    = 8'h00;
      valueA = (32'(sel) << (A + 1)) | (32'(wr) << A) | (idx & ((32'd1 << A) - 32'd1));
      valueB = data;
      lat    = -1;
      res    = '0;
      #1;
      if (done) begin
         lat = 0;
         res = result;
      end
      @(negedge clock);
      start  = 1'b0;
      valueA = '0;
      valueB = '0;
      for (int i = 1; i <= 4 && lat < 0; i++) begin
         #1;
         if (done) begin
            lat = i;
            res = result;
         end else begin
            @(negedge clock);
         end
      end
   endtask

   task automatic reg_wr(input logic [2:0] sel, input logic [31:0] v);
      logic [31:0] r;
      int l;
      ci(1'b1, sel, 0, v, r, l);
   endtask

   task automatic reg_rd(input logic [2:0] sel, output logic [31:0] v);
      int l;
      ci(1'b0, sel, 0, 0, v, l);
   endtask

   task automatic mem_wr(input int idx, input logic [31:0] v);
      logic [31:0] r;
      int l;
      ci(1'b1, SelMem, idx, v, r, l);
   endtask

   task automatic mem_chk(input string tag, input int idx);
      logic [31:0] r, e;
      int l;
      ci(1'b0, SelMem, idx, 0, r, l);
      chk({tag, "_lat"}, 32'(l), 32'd1);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
      chk(tag, r, e);
   endtask

   task automatic outs_zero(input string tag);
      chk({tag, "_ctl"}, 32'({request, begin_transaction_out, end_transaction_out, data_valid_out,
                              read_n_write_out, irq, done, byte_enables_out, burst_size_out}), 32'd0);
      chk({tag, "_ad"}, address_data_out, 32'd0);
      chk({tag, "_res"}, result, 32'd0);
   endtask

   task automatic grant_begin(input logic [31:0] ea, input logic [7:0] ebs, input logic erw);
      int n = 0;
      @(negedge clock);
      #1;
      while (!request && n < 40) begin
         @(negedge clock);
         #1;
         n++;
      end
      chk("req_seen", 32'(request), 32'd1);
      granted = 1'b1;
      @(negedge clock);
      granted = 1'b0;
      #1;
      chk("begin", 32'(begin_transaction_out), 32'd1);
      chk("begin_addr", address_data_out, ea);
      chk("burst_size", 32'(burst_size_out), 32'(ebs));
      chk("rnw", 32'(read_n_write_out), 32'(erw));
      chk("be_begin", 32'(byte_enables_out), 32'hF);
   endtask

   task automatic rd_data(input int beats, input int err_at, input logic [31:0] base);
      for (int i = 0; i < beats; i++) begin
         @(negedge clock);
         if (i == err_at) begin
            data_valid_in      = 1'b0;
            end_transaction_in = 1'b0;
            error_in           = 1'b1;
            @(negedge clock);
            error_in = 1'b0;
            #1;
            chk("err_end", 32'(end_transaction_out), 32'd1);
            chk("err_irq", 32'(irq), 32'd1);
            return;
         end
         data_valid_in      = 1'b1;
         address_data_in    = base + 32'(i);
         end_transaction_in = (i == beats - 1);
         exp_q.push_back(base + 32'(i));
      end
      @(negedge clock);
      data_valid_in      = 1'b0;
      end_transaction_in = 1'b0;
      address_data_in    = '0;
   endtask

   initial begin
      logic [31:0] r;
      int          l, irq_base, beat, hold, ends;

      reset_n = 1'b1;
      start = 1'b0; ciN = '0; valueA = '0; valueB = '0; granted = 1'b0;
      address_data_in = '0; end_transaction_in = 1'b0; data_valid_in = 1'b0;
      busy_in = 1'b0; error_in = 1'b0;
      #2 reset_n = 1'b0;
      repeat (3) @(negedge clock);
      #1;
      outs_zero("reset");
      reset_n = 1'b1;

      // CI buffer write then read
      ci(1'b1, SelMem, 32'h1F5, 32'hCAFEBABE, r, l);
      chk("t1_wr_lat", 32'(l), 32'd0);
      ci(1'b0, SelMem, 32'h1F5, 0, r, l);
      chk("t1_rd_lat", 32'(l), 32'd1);
      chk("t1_rd", r, 32'hCAFEBABE);

      // Nonzero upper bits: done, zero result, no write
      mem_wr(5, 32'h0000_0055);
      @(negedge clock);
      start  = 1'b1;
      valueA = 32'h8000_0000 | (32'd1 << A) | 32'd5;
      valueB = 32'h0000_1234;
      #1;
      chk("bad_done", 32'(done), 32'd1);
      chk("bad_res", result, 32'd0);
      ciN = 8'h01;
      valueA = 32'(SelStatus) << (A + 1);
      #1;
      chk("other_id_done", 32'(done), 32'd0);
      @(negedge clock);
      start = 1'b0; ciN = 8'h00; valueA = '0; valueB = '0;
      exp_q.push_back(32'h0000_0055);
      mem_chk("bad_nowrite", 5);

      // Bus->buffer, 10 words in bursts of 4,4,2
      reg_wr(SelBurst, 32'd200);
      reg_rd(SelBurst, r);
      chk("burst_clamp", r, 32'd15);
      reg_wr(SelBusAddr, 32'h0000_1003);
      reg_rd(SelBusAddr, r);
      chk("busaddr_align", r, 32'h0000_1000);
      reg_wr(SelBufAddr, 0);
      reg_wr(SelBlkSize, 10);
      reg_wr(SelBurst, 3);
      irq_base = irq_cnt;
      reg_wr(SelCtrl, 1);
      grant_begin(32'h1000, 8'd3, 1'b1);
      rd_data(4, -1, 32'hA000);
      grant_begin(32'h1010, 8'd3, 1'b1);
      rd_data(4, -1, 32'hA004);
      grant_begin(32'h1020, 8'd1, 1'b1);
      rd_data(2, -1, 32'hA008);
      reg_rd(SelStatus, r);
      chk("t2_status", r, 32'h4);
      chk("t2_irq", 32'(irq_cnt - irq_base), 32'd1);
      for (int i = 0; i < 10; i++) mem_chk("t2_buf", i);

      // Buffer->bus, 8 beats, slave stalls beat 3 for two cycles
      for (int i = 0; i < 8; i++) begin
         mem_wr(i, 32'hB000 + 32'(i * 17));
         exp_q.push_back(32'hB000 + 32'(i * 17));
      end
      reg_wr(SelBusAddr, 32'h2000);
      reg_wr(SelBufAddr, 0);
      reg_wr(SelBlkSize, 8);
      reg_wr(SelBurst, 7);
      irq_base = irq_cnt;
      reg_wr(SelCtrl, 2);
      reg_wr(SelBusAddr, 32'h9990);
      reg_rd(SelBusAddr, r);
      chk("busy_wr_ignored", r, 32'h2000);
      grant_begin(32'h2000, 8'd7, 1'b0);
      beat = 0; hold = 0; ends = 0;
      for (int c = 0; c < 16; c++) begin
         @(negedge clock);
         busy_in = (beat == 3 && hold < 2);
         #1;
         if (end_transaction_out) ends++;
         if (data_valid_out) begin
            if (busy_in) begin
               hold++;
               chk("t3_held", address_data_out, (exp_q.size() > 0) ? exp_q[0] : 32'hDEAD_BEEF);
            end else begin
               chk("t3_beat", address_data_out,
                   (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF);
               beat++;
            end
         end
      end
      busy_in = 1'b0;
      chk("t3_beats", 32'(beat), 32'd8);
      chk("t3_holds", 32'(hold), 32'd2);
      chk("t3_ends", 32'(ends), 32'd1);
      chk("t3_irq", 32'(irq_cnt - irq_base), 32'd1);
      reg_rd(SelStatus, r);
      chk("t3_status", r, 32'h4);

      // Error on third beat of a read
      reg_wr(SelBusAddr, 32'h3000);
      reg_wr(SelBufAddr, 32'h20);
      reg_wr(SelBlkSize, 8);
      reg_wr(SelBurst, 7);
      irq_base = irq_cnt;
      reg_wr(SelCtrl, 1);
      grant_begin(32'h3000, 8'd7, 1'b1);
      rd_data(8, 2, 32'hC000);
      reg_rd(SelStatus, r);
      chk("t4_status", r, 32'h2);
      reg_rd(SelBusAddr, r);
      chk("t4_busaddr", r, 32'h3008);
      reg_rd(SelBufAddr, r);
      chk("t4_bufaddr", r, 32'h22);
      chk("t4_irq", 32'(irq_cnt - irq_base), 32'd1);
      mem_chk("t4_buf", 32'h20);
      mem_chk("t4_buf", 32'h21);

      // Buffer address wraps modulo depth
      reg_wr(SelBusAddr, 32'h4000);
      reg_wr(SelBufAddr, (1 << A) - 2);
      reg_wr(SelBlkSize, 4);
      reg_wr(SelBurst, 15);
      reg_wr(SelCtrl, 1);
      grant_begin(32'h4000, 8'd3, 1'b1);
      rd_data(4, -1, 32'hD000);
      reg_rd(SelStatus, r);
      chk("t5_status", r, 32'h4);
      reg_rd(SelBufAddr, r);
      chk("t5_bufaddr", r, 32'd2);
      mem_chk("t5_buf", (1 << A) - 2);
      mem_chk("t5_buf", (1 << A) - 1);
      mem_chk("t5_buf", 0);
      mem_chk("t5_buf", 1);

      // Asynchronous reset in the middle of a write burst
      reg_wr(SelBusAddr, 32'h5000);
      reg_wr(SelBufAddr, 0);
      reg_wr(SelBlkSize, 4);
      reg_wr(SelBurst, 3);
      reg_wr(SelCtrl, 2);
      grant_begin(32'h5000, 8'd3, 1'b0);
      @(negedge clock);
      #1;
      chk("t6_dv", 32'(data_valid_out), 32'd1);
      reset_n = 1'b0;
      #1;
      outs_zero("t6_rst");
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
      reg_rd(SelBusAddr, r);
      chk("t6_busaddr", r, 32'd0);
      reg_rd(SelBufAddr, r);
      chk("t6_bufaddr", r, 32'd0);
      reg_rd(SelBlkSize, r);
      chk("t6_blk", r, 32'd0);
      reg_rd(SelBurst, r);
      chk("t6_burst", r, 32'd0);
      reg_rd(SelStatus, r);
      chk("t6_status", r, 32'd0);
      @(negedge clock);
      #1;
      chk("t6_req", 32'(request), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
